// File: rtl/mc_datapath_regs.sv
// Multi-cycle datapath register bank: PC, IR, MDR, operand latches, ALUOut,
// sticky ecall halt flag and retired/cycle counters.
module mc_datapath_regs (
    input  logic        reset,
    input  logic        clk,
    input  logic        PCWrite,
    input  logic        PCWriteNotCond,
    input  logic        PCSource,
    input  logic        IRWrite,
    input  logic        IorD,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        is_ecall,
    input  logic [31:0] alu_result,
    input  logic        alu_bcond,
    input  logic [31:0] target_addr,
    input  logic [31:0] mem_dout,
    input  logic [31:0] rs1_dout,
    input  logic [31:0] rs2_dout,
    input  logic [31:0] x17_value,
    output logic [31:0] current_pc,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    output logic [31:0] mdr,
    output logic [31:0] a_reg,
    output logic [31:0] b_reg,
    output logic [31:0] alu_out,
    output logic [31:0] mem_addr,
    output logic        is_halted,
    output logic [31:0] retired_count,
    output logic [31:0] cycle_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic        halted_q, halted_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] cycle_q, cycle_d;

    logic        pc_en;
    logic [31:0] next_pc;
    logic        run;
    logic        halt_req;
    logic        unused_mem_write;

    assign unused_mem_write = mem_write;

    assign pc_en    = PCWrite | (~PCWriteNotCond & alu_bcond);
    assign next_pc  = PCSource ? target_addr : alu_result;
    assign run      = ~halted_q;
    assign halt_req = is_ecall & ~IRWrite & (x17_value == 32'd10);

    always_comb begin
        pc_d      = pc_q;
        inst_pc_d = inst_pc_q;
        inst_d    = inst_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        halted_d  = halted_q | halt_req;
        retired_d = retired_q;
        cycle_d   = cycle_q;
        if (run) begin
            if (pc_en) pc_d = next_pc;
            // inst_pc takes the pre-update PC even when the PC also moves this edge
            if (IRWrite) begin
                inst_d    = mem_dout;
                inst_pc_d = pc_q;
                retired_d = retired_q + 32'd1;
            end
            if (mem_read && IorD) mdr_d = mem_dout;
            a_d       = rs1_dout;
            b_d       = rs2_dout;
            alu_out_d = alu_result;
            cycle_d   = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= 32'd0;
            inst_pc_q <= 32'd0;
            inst_q    <= 32'd0;
            mdr_q     <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
            halted_q  <= 1'b0;
            retired_q <= 32'd0;
            cycle_q   <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            cycle_q   <= cycle_d;
        end
    end

    assign current_pc    = pc_q;
    assign inst_pc       = inst_pc_q;
    assign inst          = inst_q;
    assign mdr           = mdr_q;
    assign a_reg         = a_q;
    assign b_reg         = b_q;
    assign alu_out       = alu_out_q;
    assign mem_addr      = IorD ? alu_out_q : pc_q;
    assign is_halted     = halted_q;
    assign retired_count = retired_q;
    assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed bench for mc_datapath_regs: fetch, branch, load, halt, reset and
// counter wrap, with hand-computed expectations.
module tb_mc_datapath_regs;

    logic        reset, clk;
    logic        PCWrite, PCWriteNotCond, PCSource, IRWrite, IorD;
    logic        mem_read, mem_write, is_ecall, alu_bcond;
    logic [31:0] alu_result, target_addr, mem_dout, rs1_dout, rs2_dout, x17_value;
    logic [31:0] current_pc, inst_pc, inst, mdr, a_reg, b_reg, alu_out, mem_addr;
    logic [31:0] retired_count, cycle_count;
    logic        is_halted;

    int n_checks = 0;
    int n_errors = 0;

    mc_datapath_regs dut (
        .reset         (reset),
        .clk           (clk),
        .PCWrite       (PCWrite),
        .PCWriteNotCond(PCWriteNotCond),
        .PCSource      (PCSource),
        .IRWrite       (IRWrite),
        .IorD          (IorD),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .is_ecall      (is_ecall),
        .alu_result    (alu_result),
        .alu_bcond     (alu_bcond),
        .target_addr   (target_addr),
        .mem_dout      (mem_dout),
        .rs1_dout      (rs1_dout),
        .rs2_dout      (rs2_dout),
        .x17_value     (x17_value),
        .current_pc    (current_pc),
        .inst_pc       (inst_pc),
        .inst          (inst),
        .mdr           (mdr),
        .a_reg         (a_reg),
        .b_reg         (b_reg),
        .alu_out       (alu_out),
        .mem_addr      (mem_addr),
        .is_halted     (is_halted),
        .retired_count (retired_count),
        .cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCWrite = 0; PCWriteNotCond = 0; PCSource = 0; IRWrite = 0; IorD = 0;
        mem_read = 0; mem_write = 0; is_ecall = 0; alu_bcond = 0;
        alu_result = 0; target_addr = 0; mem_dout = 0;
        rs1_dout = 0; rs2_dout = 0; x17_value = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pc"}, current_pc, 32'd0);
        check_eq({tag, "_inst_pc"}, inst_pc, 32'd0);
        check_eq({tag, "_inst"}, inst, 32'd0);
        check_eq({tag, "_mdr"}, mdr, 32'd0);
        check_eq({tag, "_a"}, a_reg, 32'd0);
        check_eq({tag, "_b"}, b_reg, 32'd0);
        check_eq({tag, "_alu_out"}, alu_out, 32'd0);
        check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
        check_eq({tag, "_halted"}, {31'd0, is_halted}, 32'd0);
        check_eq({tag, "_retired"}, retired_count, 32'd0);
        check_eq({tag, "_cycle"}, cycle_count, 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        PCWrite = 1; IRWrite = 1; alu_result = 32'h1234; mem_dout = 32'h5555;
        step();
        step();
        check_all_zero("reset");
        idle_inputs();
        reset = 0;

        // Fetch at PC 0
        IRWrite = 1; PCWrite = 1; mem_dout = 32'h0050_0093; alu_result = 32'd4;
        rs1_dout = 32'h11; rs2_dout = 32'h22;
        step();
        check_eq("fetch_inst", inst, 32'h0050_0093);
        check_eq("fetch_inst_pc", inst_pc, 32'd0);
        check_eq("fetch_pc", current_pc, 32'd4);
        check_eq("fetch_retired", retired_count, 32'd1);
        check_eq("fetch_a", a_reg, 32'h11);
        check_eq("fetch_b", b_reg, 32'h22);
        check_eq("fetch_alu_out", alu_out, 32'd4);
        check_eq("fetch_mdr", mdr, 32'd0);

        // Conditional branch taken
        idle_inputs();
        alu_bcond = 1; PCSource = 1; target_addr = 32'h40; alu_result = 32'h99;
        step();
        check_eq("br_taken_pc", current_pc, 32'h40);
        check_eq("br_alu_out", alu_out, 32'h99);
        check_eq("br_retired", retired_count, 32'd1);

        // Not taken
        alu_bcond = 0; target_addr = 32'h80;
        step();
        check_eq("br_not_taken_pc", current_pc, 32'h40);

        // PCWriteNotCond set masks the condition
        PCWriteNotCond = 1; alu_bcond = 1;
        step();
        check_eq("br_notcond_pc", current_pc, 32'h40);

        // Load: preload ALUOut with address, then access with IorD=1
        idle_inputs();
        alu_result = 32'h100;
        step();
        check_eq("ld_mem_addr_pc", mem_addr, 32'h40);
        IorD = 1; mem_read = 1; mem_dout = 32'hDEAD_BEEF; alu_result = 32'h5;
        #1;
        check_eq("ld_mem_addr", mem_addr, 32'h100);
        step();
        check_eq("ld_mdr", mdr, 32'hDEAD_BEEF);
        check_eq("ld_pc_hold", current_pc, 32'h40);

        // Write and IorD=0 reads leave MDR alone
        mem_read = 0; mem_write = 1; mem_dout = 32'h1111_2222;
        step();
        check_eq("st_mdr_hold", mdr, 32'hDEAD_BEEF);
        mem_write = 0; mem_read = 1; IorD = 0; mem_dout = 32'h3333_4444;
        step();
        check_eq("rd_iord0_mdr_hold", mdr, 32'hDEAD_BEEF);
        check_eq("cycle_8", cycle_count, 32'd8);

        // Second fetch at 0x40
        idle_inputs();
        IRWrite = 1; PCWrite = 1; mem_dout = 32'h0000_0073; alu_result = 32'h44;
        step();
        check_eq("fetch2_inst_pc", inst_pc, 32'h40);
        check_eq("fetch2_pc", current_pc, 32'h44);
        check_eq("fetch2_retired", retired_count, 32'd2);

        // ecall with x17=9: no halt
        idle_inputs();
        is_ecall = 1; x17_value = 32'd9;
        step();
        check_eq("ecall9_halted", {31'd0, is_halted}, 32'd0);

        // ecall with x17=10 but IRWrite=1: no halt
        is_ecall = 1; x17_value = 32'd10; IRWrite = 1; mem_dout = 32'h0000_0073;
        step();
        check_eq("ecall_ir_halted", {31'd0, is_halted}, 32'd0);
        check_eq("ecall_ir_retired", retired_count, 32'd3);
        check_eq("ecall_ir_inst_pc", inst_pc, 32'h44);

        // ecall with x17=10: halt next edge
        IRWrite = 0; rs1_dout = 32'h77;
        step();
        check_eq("halt_set", {31'd0, is_halted}, 32'd1);
        check_eq("halt_edge_a", a_reg, 32'h77);
        check_eq("halt_cycle", cycle_count, 32'd12);

        // Frozen while halted
        idle_inputs();
        IRWrite = 1; PCWrite = 1; mem_read = 1; IorD = 1; alu_result = 32'h1234;
        mem_dout = 32'hFFFF; rs1_dout = 32'h55; rs2_dout = 32'h66;
        step();
        step();
        check_eq("halt_sticky", {31'd0, is_halted}, 32'd1);
        check_eq("halt_pc", current_pc, 32'h44);
        check_eq("halt_inst", inst, 32'h0000_0073);
        check_eq("halt_inst_pc", inst_pc, 32'h44);
        check_eq("halt_mdr", mdr, 32'hDEAD_BEEF);
        check_eq("halt_a", a_reg, 32'h77);
        check_eq("halt_alu_out", alu_out, 32'h0);
        check_eq("halt_retired", retired_count, 32'd3);
        check_eq("halt_cycle_frozen", cycle_count, 32'd12);

        // Reset while halted with write enables active
        reset = 1;
        step();
        IorD = 0;
        check_all_zero("reset_mid");
        reset = 0;
        idle_inputs();

        // Retired counter wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        check_eq("wrap_preload", retired_count, 32'hFFFF_FFFF);
        IRWrite = 1;
        step();
        check_eq("wrap_retired", retired_count, 32'd0);
        check_eq("wrap_cycle", cycle_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
